// File: rtl/trigger_wheel_gen.sv
// Missing-tooth crank wheel generator: N slots per rev, the last M are missing, P clocks per slot.
// Tooth period is taken at slot boundaries; tooth and gap counts are taken only at revolution end.
module trigger_wheel_gen #(
    parameter int unsigned PERIOD_W = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CNT_W-1:0]    tooth_cnt,
    input  logic [CNT_W-1:0]    teeth_missing,
    input  logic [PERIOD_W-1:0] tooth_period,
    output logic                vr_out,
    output logic                sync_pulse,
    output logic [CNT_W-1:0]    tooth_idx,
    output logic [CNT_W-1:0]    rev_count,
    output logic                running,
    output logic                cfg_err
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q;
    logic [PERIOD_W-1:0] cyc_q;
    logic [PERIOD_W-1:0] per_q;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    m_q;

    logic                cfg_ok;
    logic                slot_end;
    logic                last_slot;
    logic [CNT_W-1:0]    next_slot;
    logic [PERIOD_W-1:0] next_cyc;
    logic                cur_present;
    logic                next_present;

    always_comb begin
        cfg_ok       = (tooth_cnt >= CNT_W'(2)) && (teeth_missing < tooth_cnt) &&
                       (tooth_period >= PERIOD_W'(2));
        slot_end     = (cyc_q == per_q - PERIOD_W'(1));
        last_slot    = (tooth_idx == n_q - CNT_W'(1));
        next_slot    = tooth_idx + CNT_W'(1);
        next_cyc     = cyc_q + PERIOD_W'(1);
        cur_present  = (tooth_idx < (n_q - m_q));
        next_present = (next_slot < (n_q - m_q));
    end

    // vr_out is computed from the slot/cycle position being entered, so it stays aligned with them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cyc_q      <= '0;
            per_q      <= '0;
            n_q        <= '0;
            m_q        <= '0;
            vr_out     <= 1'b0;
            sync_pulse <= 1'b0;
            tooth_idx  <= '0;
            rev_count  <= '0;
            running    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            sync_pulse <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable && cfg_ok) begin
                        state_q    <= StRun;
                        n_q        <= tooth_cnt;
                        m_q        <= teeth_missing;
                        per_q      <= tooth_period;
                        cyc_q      <= '0;
                        tooth_idx  <= '0;
                        vr_out     <= 1'b1;
                        sync_pulse <= 1'b1;
                        running    <= 1'b1;
                    end else if (enable) begin
                        cfg_err <= 1'b1;
                    end else begin
                        cfg_err <= 1'b0;
                    end
                end
                StRun: begin
                    if (!enable) begin
                        state_q   <= StIdle;
                        cyc_q     <= '0;
                        tooth_idx <= '0;
                        vr_out    <= 1'b0;
                        running   <= 1'b0;
                        cfg_err   <= 1'b0;
                    end else if (!slot_end) begin
                        cyc_q  <= next_cyc;
                        vr_out <= cur_present && (next_cyc < (per_q >> 1));
                    end else if (!last_slot) begin
                        tooth_idx <= next_slot;
                        cyc_q     <= '0;
                        per_q     <= tooth_period;
                        vr_out    <= next_present && ((tooth_period >> 1) != '0);
                    end else begin
                        rev_count <= rev_count + CNT_W'(1);
                        n_q       <= tooth_cnt;
                        m_q       <= teeth_missing;
                        per_q     <= tooth_period;
                        cyc_q     <= '0;
                        tooth_idx <= '0;
                        if (cfg_ok) begin
                            vr_out     <= 1'b1;
                            sync_pulse <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            vr_out  <= 1'b0;
                            running <= 1'b0;
                            cfg_err <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_wheel_gen.sv
// Scoreboard bench for trigger_wheel_gen: a waveform-expansion model queues expected outputs,
// a monitor pops and compares one entry per clock.
module tb_trigger_wheel_gen;

    localparam int unsigned PERIOD_W = 32;
    localparam int unsigned CNT_W    = 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic [CNT_W-1:0]    tooth_cnt;
    logic [CNT_W-1:0]    teeth_missing;
    logic [PERIOD_W-1:0] tooth_period;
    logic                vr_out;
    logic                sync_pulse;
    logic [CNT_W-1:0]    tooth_idx;
    logic [CNT_W-1:0]    rev_count;
    logic                running;
    logic                cfg_err;

    always #5 clk = ~clk;

    trigger_wheel_gen #(
        .PERIOD_W(PERIOD_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .tooth_cnt    (tooth_cnt),
        .teeth_missing(teeth_missing),
        .tooth_period (tooth_period),
        .vr_out       (vr_out),
        .sync_pulse   (sync_pulse),
        .tooth_idx    (tooth_idx),
        .rev_count    (rev_count),
        .running      (running),
        .cfg_err      (cfg_err)
    );

    typedef struct packed {
        logic             vr;
        logic             sync;
        logic [CNT_W-1:0] idx;
        logic [CNT_W-1:0] rev;
        logic             run;
        logic             err;
    } obs_t;

    typedef struct packed {
        logic             vr;
        logic             sync;
        logic [CNT_W-1:0] idx;
    } samp_t;

    obs_t  exp_q[$];
    samp_t wave_q[$];   // remaining cycles of the slot currently being played

    bit               m_run;
    bit               m_err;
    int               m_n;
    int               m_m;
    int               m_slot;
    logic [CNT_W-1:0] m_rev;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_pushed  = 0;
    int n_popped  = 0;
    int cyc_count = 0;

    function automatic bit cfg_valid();
        return (int'(tooth_cnt) >= 2) && (int'(teeth_missing) < int'(tooth_cnt)) &&
               (tooth_period >= 2);
    endfunction

    // Expand one whole slot into its per-cycle waveform.
    task automatic build_slot(input int s, input int p);
        samp_t smp;
        for (int c = 0; c < p; c++) begin
            smp.vr   = (s < (m_n - m_m)) && (c < p / 2);
            smp.sync = (s == 0) && (c == 0);
            smp.idx  = CNT_W'(s);
            wave_q.push_back(smp);
        end
    endtask

    task automatic model_edge();
        obs_t e;
        if (!reset_n) begin
            m_run = 0;
            m_err = 0;
            m_rev = '0;
            wave_q.delete();
        end else if (!m_run) begin
            if (enable && cfg_valid()) begin
                m_run  = 1;
                m_n    = int'(tooth_cnt);
                m_m    = int'(teeth_missing);
                m_slot = 0;
                build_slot(0, int'(tooth_period));
            end else begin
                m_err = enable;
            end
        end else if (!enable) begin
            m_run = 0;
            m_err = 0;
            wave_q.delete();
        end else begin
            void'(wave_q.pop_front());
            if (wave_q.size() == 0) begin
                if (m_slot < m_n - 1) begin
                    m_slot++;
                    build_slot(m_slot, int'(tooth_period));
                end else begin
                    m_rev = m_rev + 1'b1;
                    if (cfg_valid()) begin
                        m_n    = int'(tooth_cnt);
                        m_m    = int'(teeth_missing);
                        m_slot = 0;
                        build_slot(0, int'(tooth_period));
                    end else begin
                        m_run = 0;
                        m_err = 1;
                    end
                end
            end
        end
        e = '0;
        e.rev = m_rev;
        e.err = m_err;
        if (m_run) begin
            e.vr   = wave_q[0].vr;
            e.sync = wave_q[0].sync;
            e.idx  = wave_q[0].idx;
            e.run  = 1'b1;
        end
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic run_cycles(input int k);
        repeat (k) step();
    endtask

    task automatic set_cfg(input int n, input int m, input int p);
        tooth_cnt     = CNT_W'(n);
        teeth_missing = CNT_W'(m);
        tooth_period  = PERIOD_W'(p);
    endtask

    // Monitor: one comparison per clock whenever the model has an expectation queued.
    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(posedge clk);
            #1;
            cyc_count++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_popped++;
                got = '{vr: vr_out, sync: sync_pulse, idx: tooth_idx, rev: rev_count,
                        run: running, err: cfg_err};
                n_checks++;
                if (got !== e) begin
                    $display("FAIL outputs cycle %0d: got vr=%b sync=%b idx=%0d rev=%0d run=%b err=%b, required vr=%b sync=%b idx=%0d rev=%0d run=%b err=%b",
                             cyc_count, got.vr, got.sync, got.idx, got.rev, got.run, got.err,
                             e.vr, e.sync, e.idx, e.rev, e.run, e.err);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        int bound;
        int r;
        reset_n = 1'b0;
        enable  = 1'b0;
        set_cfg(4, 1, 10);
        run_cycles(3);
        reset_n = 1'b1;
        run_cycles(2);

        // Basic 4-1 wheel, three revolutions plus some.
        enable = 1'b1;
        run_cycles(125);

        // Period change takes effect at the next slot boundary.
        tooth_period = PERIOD_W'(20);
        run_cycles(60);

        // Tooth-count change takes effect at the next revolution.
        tooth_cnt = CNT_W'(6);
        run_cycles(160);

        // Invalid gap count: the rev completes, then the block parks with cfg_err.
        set_cfg(4, 4, 10);
        bound = 0;
        while (m_run && bound < 400) begin
            step();
            bound++;
        end
        n_checks++;
        if (m_run) $display("FAIL invalid_cfg_stop: model still running after %0d cycles, required stop", bound);
        else n_pass++;
        run_cycles(3);
        enable = 1'b0;
        run_cycles(3);
        set_cfg(4, 1, 5);
        enable = 1'b1;
        run_cycles(45);

        // Long 60-2 wheel for three revolutions.
        enable = 1'b0;
        run_cycles(2);
        set_cfg(60, 2, 100);
        enable = 1'b1;
        run_cycles(3 * 6000 + 10);

        // Randomized configuration, enable and reset activity on small wheels.
        set_cfg(5, 1, 6);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 6) begin
                tooth_period = PERIOD_W'($urandom_range(1, 12));
            end else if (r < 9) begin
                tooth_cnt     = CNT_W'($urandom_range(2, 8));
                teeth_missing = CNT_W'($urandom_range(0, int'(tooth_cnt) - 1));
                tooth_period  = PERIOD_W'($urandom_range(2, 12));
            end else if (r == 9) begin
                case ($urandom_range(0, 2))
                    0:       tooth_cnt = CNT_W'(1);
                    1:       teeth_missing = tooth_cnt;
                    default: tooth_period = PERIOD_W'(1);
                endcase
            end else if (r == 10) begin
                enable = ~enable;
            end else if (r == 11) begin
                reset_n = 1'b0;
            end else if (!enable && r < 40) begin
                enable = 1'b1;
            end
            step();
            reset_n = 1'b1;
        end

        // Abort mid-slot holds rev_count; reset then clears it.
        set_cfg(4, 1, 10);
        enable = 1'b0;
        run_cycles(2);
        enable = 1'b1;
        run_cycles(43);
        enable = 1'b0;
        run_cycles(3);
        reset_n = 1'b0;
        run_cycles(2);
        reset_n = 1'b1;
        run_cycles(2);

        repeat (3) @(posedge clk);
        n_checks++;
        if (n_popped != n_pushed)
            $display("FAIL scoreboard_drain: got %0d compared, required %0d", n_popped, n_pushed);
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
